multicycle_controller: RTL and testbench

Multi-cycle sequencer for the Eka RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and drives the enables for the PC, IR, register file, ALU and data-memory port from the instruction decoder's control outputs. It sits beside the decoder and datapath; the decoder stays purely combinational. The controller adds instruction and data memory request/acknowledge handshakes, an acknowledge timeout, illegal-opcode and bus-error trapping, and a retired-instruction counter.

---
 rtl/eka_pkg.sv | 36 +++
 rtl/ack_timeout_counter.sv | 41 ++++
 rtl/multicycle_controller.sv | 165 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eka_pkg.sv
// Shared definitions for the Eka RV32I core: controller state encoding,
// major opcodes recognised by the controller/decoder, and trap causes.
package eka_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  // True for the five major opcodes this core implements.
  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      OP_IMM, OP_REG, OP_BRANCH, OP_STORE, OP_LOAD: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/ack_timeout_counter.sv
// Wait-cycle counter for a request/acknowledge handshake. Held at zero while
// clear is high, counts each enabled cycle, and flags the cycle in which the
// count sits on limit-1. A limit of zero never expires.
module ack_timeout_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear dominates, otherwise advance on every waiting cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The caller masks this with its ack so an ack in the limit cycle wins.
  assign expired_o = enable_i && !clear_i && (limit_i != '0) &&
                     (cnt_q == (limit_i - W'(1)));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the Eka RV32I core. Steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, runs the memory handshakes with an
// acknowledge timeout, traps on illegal opcodes or bus timeouts, and counts
// retired instructions.
module multicycle_controller
  import eka_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             dec_write_en,
  input  logic             dec_mem_read_en,
  input  logic             dec_mem_write_en,
  input  logic             dec_branch_inst,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             opnd_load,
  output logic             alu_en,
  output logic             rf_write,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  // Counter must hold values up to ACK_TIMEOUT-1 and the limit itself.
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(ACK_TIMEOUT);

  state_e           state_q;
  state_e           state_d;
  logic [1:0]       cause_q;
  logic [1:0]       cause_d;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic             retire;
  logic             in_fetch;
  logic             in_mem;
  logic             imem_expired;
  logic             dmem_expired;

  assign in_fetch = (state_q == ST_FETCH);
  assign in_mem   = (state_q == ST_MEM);

  // Counters are cleared outside their request state, so each entry starts at zero.
  ack_timeout_counter #(.W(TW)) u_imem_to (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!in_fetch),
    .enable_i  (in_fetch && !imem_ack),
    .limit_i   (LIMIT),
    .expired_o (imem_expired)
  );

  ack_timeout_counter #(.W(TW)) u_dmem_to (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!in_mem),
    .enable_i  (in_mem && !dmem_ack),
    .limit_i   (LIMIT),
    .expired_o (dmem_expired)
  );

  // Sequencing: next state, trap cause and retire qualifier.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (imem_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (!is_legal_opcode(opcode)) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (dec_branch_inst) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (dec_mem_read_en || dec_mem_write_en) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (dec_mem_write_en) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (dmem_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      ST_WRITEBACK: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Retired-instruction count wraps naturally at 2^CNT_W.
  always_comb begin
    retired_d = retired_q;
    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // State, trap cause and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // Strobes decode from registered state; only ack/branch qualifiers are combinational.
  assign imem_req      = in_fetch;
  assign ir_load       = in_fetch && imem_ack;
  assign opnd_load     = (state_q == ST_DECODE);
  assign alu_en        = (state_q == ST_EXECUTE);
  assign dmem_req      = in_mem;
  assign dmem_we       = in_mem && dec_mem_write_en;
  assign rf_write      = (state_q == ST_WRITEBACK);
  assign pc_write      = (state_q == ST_WRITEBACK) ||
                         ((state_q == ST_EXECUTE) && dec_branch_inst) ||
                         (in_mem && dmem_ack && dec_mem_write_en);
  assign pc_sel_branch = (state_q == ST_EXECUTE) && dec_branch_inst && branch_taken;
  assign trap          = (state_q == ST_TRAP);
  assign trap_cause    = cause_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller. A responder plays the
// instruction/data memories and the decoder; expected per-instruction
// behaviour is queued when the program is built and compared by a monitor.
module tb_multicycle_controller;

  localparam int TO    = 16;
  localparam int NEVER = 1000;

  localparam logic [6:0] T_IMM    = 7'b0010011;
  localparam logic [6:0] T_REG    = 7'b0110011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_BAD    = 7'h7F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, dec_write_en, dec_mem_read_en, dec_mem_write_en, dec_branch_inst;
  logic        branch_taken, imem_ack, dmem_ack;
  logic [6:0]  opcode;
  logic        imem_req, dmem_req, dmem_we, ir_load, opnd_load, alu_en, rf_write;
  logic        pc_write, pc_sel_branch, trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  logic        reset0, imem_ack0, dmem_ack0;
  logic        imem_req0, dmem_req0, dmem_we0, ir_load0, opnd_load0, alu_en0, rf_write0;
  logic        pc_write0, pc_sel_branch0, trap0;
  logic [1:0]  trap_cause0;
  logic [31:0] retired0;

  multicycle_controller #(.ACK_TIMEOUT(TO), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .dec_write_en(dec_write_en),
    .dec_mem_read_en(dec_mem_read_en), .dec_mem_write_en(dec_mem_write_en),
    .dec_branch_inst(dec_branch_inst), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_load(ir_load), .opnd_load(opnd_load), .alu_en(alu_en),
    .rf_write(rf_write), .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  multicycle_controller #(.ACK_TIMEOUT(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset(reset0), .opcode(opcode), .dec_write_en(dec_write_en),
    .dec_mem_read_en(dec_mem_read_en), .dec_mem_write_en(dec_mem_write_en),
    .dec_branch_inst(dec_branch_inst), .branch_taken(branch_taken),
    .imem_ack(imem_ack0), .dmem_ack(dmem_ack0), .imem_req(imem_req0), .dmem_req(dmem_req0),
    .dmem_we(dmem_we0), .ir_load(ir_load0), .opnd_load(opnd_load0), .alu_en(alu_en0),
    .rf_write(rf_write0), .pc_write(pc_write0), .pc_sel_branch(pc_sel_branch0),
    .trap(trap0), .trap_cause(trap_cause0), .retired(retired0)
  );

  typedef struct {
    logic [6:0] op;
    logic       taken;
    int         idly;
    int         ddly;
  } instr_t;

  typedef struct {
    int          is_trap;
    int          lat;
    int          sel;
    int          rfw;
    int          dreq;
    int          dwe;
    int          cause;
    logic [31:0] ret_after;
  } exp_t;

  instr_t      prog_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_ret;
  logic        pend = 1'b0;
  logic [31:0] pend_val;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: cycle counts from the per-class rules (fetch takes 1+wait cycles).
  function automatic exp_t model(input instr_t in);
    exp_t e;
    int   f;
    f = 1 + in.idly;
    e.is_trap = 0; e.lat = 0; e.sel = 0; e.rfw = 0; e.dreq = 0; e.dwe = 0;
    e.cause = 0; e.ret_after = 32'd0;
    if (in.idly >= TO) begin
      e.is_trap = 1; e.cause = 2; e.lat = TO + 1;
      return e;
    end
    case (in.op)
      T_IMM, T_REG: begin e.lat = f + 3; e.rfw = 1; end
      T_BRANCH:     begin e.lat = f + 2; e.sel = in.taken ? 1 : 0; end
      T_STORE, T_LOAD: begin
        if (in.ddly >= TO) begin
          e.is_trap = 1; e.cause = 3; e.lat = f + 2 + TO + 1;
        end else begin
          e.dreq = 1 + in.ddly;
          e.dwe  = (in.op == T_STORE) ? 1 : 0;
          e.rfw  = (in.op == T_LOAD) ? 1 : 0;
          e.lat  = f + 2 + e.dreq + e.rfw;
        end
      end
      default: begin e.is_trap = 1; e.cause = 1; e.lat = f + 2; end
    endcase
    return e;
  endfunction

  task automatic push_instr(input logic [6:0] op, input logic taken, input int idly, input int ddly);
    instr_t in;
    exp_t   e;
    in.op = op; in.taken = taken; in.idly = idly; in.ddly = ddly;
    prog_q.push_back(in);
    e = model(in);
    if (e.is_trap == 0) model_ret = model_ret + 32'd1;
    e.ret_after = model_ret;
    exp_q.push_back(e);
  endtask

  function automatic int rnd_dly();
    return ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
  endfunction

  task automatic push_random();
    logic [6:0] ops[5];
    ops[0] = T_IMM; ops[1] = T_REG; ops[2] = T_BRANCH; ops[3] = T_STORE; ops[4] = T_LOAD;
    push_instr(ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), rnd_dly(), rnd_dly());
  endtask

  task automatic drive_decoder(input instr_t in);
    opcode           = in.op;
    branch_taken     = in.taken;
    dec_write_en     = (in.op == T_IMM || in.op == T_REG || in.op == T_LOAD);
    dec_mem_read_en  = (in.op == T_LOAD);
    dec_mem_write_en = (in.op == T_STORE);
    dec_branch_inst  = (in.op == T_BRANCH);
  endtask

  // Memory/decoder responder for the main DUT.
  instr_t cur;
  logic   have = 1'b0;
  int     icnt = 0;
  int     dcnt = 0;
  initial begin
    imem_ack = 1'b0; dmem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        have = 1'b0; icnt = 0; dcnt = 0; imem_ack = 1'b0; dmem_ack = 1'b0;
      end else begin
        if (imem_req) begin
          if (icnt == 0) begin
            have = (prog_q.size() > 0);
            if (have) cur = prog_q.pop_front();
          end
          imem_ack = have && (icnt == cur.idly);
          if (imem_ack) drive_decoder(cur);
          icnt++;
        end else begin
          imem_ack = 1'b0; icnt = 0;
        end
        if (dmem_req) begin
          dmem_ack = have && (dcnt == cur.ddly);
          dcnt++;
        end else begin
          dmem_ack = 1'b0; dcnt = 0;
        end
      end
    end
  end

  // Monitor: pops one expectation per retire or trap entry.
  int   cyc = 0, n_ir = 0, n_op = 0, n_alu = 0, n_rf = 0, n_dreq = 0, m_dwe = 0;
  logic prev_req = 1'b0, prev_trap = 1'b0;
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        cyc = 0; prev_req = 1'b0; prev_trap = 1'b0; pend = 1'b0;
        continue;
      end
      if (pend) begin
        check("retired_count", retired, pend_val);
        pend = 1'b0;
      end
      if (imem_req && !prev_req) begin
        cyc = 1; n_ir = 0; n_op = 0; n_alu = 0; n_rf = 0; n_dreq = 0; m_dwe = 0;
      end else begin
        cyc++;
      end
      n_ir += int'(ir_load); n_op += int'(opnd_load); n_alu += int'(alu_en);
      n_rf += int'(rf_write); n_dreq += int'(dmem_req);
      if (dmem_req && dmem_we) m_dwe = 1;
      if (pc_write) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_retire actual=pc_write required=no_retire");
        end else begin
          me = exp_q.pop_front();
          check("retire_not_trap", 0, me.is_trap);
          check("latency", cyc, me.lat);
          check("pc_sel_branch", pc_sel_branch, me.sel);
          check("rf_write_pulses", n_rf, me.rfw);
          check("ir_load_pulses", n_ir, 1);
          check("opnd_load_pulses", n_op, 1);
          check("alu_en_cycles", n_alu, 1);
          check("dmem_req_cycles", n_dreq, me.dreq);
          check("dmem_we", m_dwe, me.dwe);
          pend = 1'b1; pend_val = me.ret_after;
        end
      end
      if (trap && !prev_trap) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_trap actual=trap required=no_trap");
        end else begin
          me = exp_q.pop_front();
          check("trap_expected", 1, me.is_trap);
          check("trap_latency", cyc, me.lat);
          check("trap_cause", trap_cause, me.cause);
        end
      end
      prev_req = imem_req; prev_trap = trap;
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_ret = 32'd0;
    prog_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; reset0 = 1'b1; imem_ack0 = 1'b0; dmem_ack0 = 1'b0;
    opcode = 7'd0; dec_write_en = 1'b0; dec_mem_read_en = 1'b0;
    dec_mem_write_en = 1'b0; dec_branch_inst = 1'b0; branch_taken = 1'b0;
    model_ret = 32'd0;
    repeat (3) tick();
    check("reset_outputs", {imem_req, dmem_req, dmem_we, ir_load, opnd_load, alu_en,
                            rf_write, pc_write, pc_sel_branch, trap, trap_cause}, 0);
    check("reset_retired", retired, 0);

    // Directed ADDI, BEQ taken, LW with 3 wait cycles, SW acked in limit cycle, then random.
    push_instr(T_IMM, 1'b0, 0, 0);
    push_instr(T_BRANCH, 1'b1, 0, 0);
    push_instr(T_LOAD, 1'b0, 0, 3);
    push_instr(T_STORE, 1'b0, 0, TO - 1);
    push_instr(T_BRANCH, 1'b0, TO - 1, 0);
    for (int i = 0; i < 40; i++) push_random();
    release_reset();
    #3;
    check("idle_after_release", imem_req, 0);
    drain();
    do_reset();

    // Illegal opcode traps and stays halted.
    push_random();
    push_random();
    push_instr(T_BAD, 1'b0, 1, 0);
    release_reset();
    drain();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n += int'(imem_req);
    end
    check("no_imem_req_in_trap", n, 0);
    check("trap_held", trap, 1);
    check("trap_cause_held", trap_cause, 1);
    do_reset();

    // Data and instruction acknowledge timeouts.
    push_instr(T_LOAD, 1'b0, 2, NEVER);
    release_reset();
    drain();
    do_reset();
    push_instr(T_IMM, 1'b0, NEVER, 0);
    release_reset();
    drain();
    do_reset();

    // Asynchronous reset in the MEM cycle of a store.
    push_instr(T_IMM, 1'b0, 0, 0);
    prog_q.push_back('{op: T_STORE, taken: 1'b0, idly: 0, ddly: NEVER});
    release_reset();
    n = 0;
    while (!dmem_req && n < 100) begin tick(); n++; end
    check("sw_reached_mem", dmem_req, 1);
    tick();
    check("retired_before_reset", retired, 1);
    check("sw_dmem_we", dmem_we, 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {imem_req, dmem_req, dmem_we, ir_load, opnd_load, alu_en,
                                  rf_write, pc_write, pc_sel_branch, trap, trap_cause}, 0);
    check("async_reset_retired", retired, 0);
    model_ret = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    check("restart_idle", imem_req, 0);
    tick();
    check("restart_fetch", imem_req, 1);
    do_reset();

    // Retire counter wrap from all-ones.
    release_reset();
    #1;
    force u_dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.retired_q;
    model_ret = 32'hFFFF_FFFF;
    push_instr(T_REG, 1'b0, 0, 0);
    drain();
    check("wrap_retired", retired, 0);
    do_reset();

    // Timeout disabled: MEM waits indefinitely.
    @(negedge clk);
    reset0 = 1'b0;
    n = 0;
    while (!imem_req0 && n < 10) begin @(negedge clk); n++; end
    check("dut0_fetch", imem_req0, 1);
    opcode = T_LOAD; dec_write_en = 1'b1; dec_mem_read_en = 1'b1;
    dec_mem_write_en = 1'b0; dec_branch_inst = 1'b0; branch_taken = 1'b0;
    imem_ack0 = 1'b1;
    @(negedge clk);
    imem_ack0 = 1'b0;
    n = 0;
    while (!dmem_req0 && n < 10) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    #3;
    check("dut0_still_waiting", dmem_req0, 1);
    check("dut0_no_trap", trap0, 0);
    dmem_ack0 = 1'b1;
    @(negedge clk);
    dmem_ack0 = 1'b0;
    #3;
    check("dut0_writeback", rf_write0, 1);
    tick();
    check("dut0_retired", retired0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
